// File: rtl/fb_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : fb_port_arbiter_if
// Desc     : Display-read, pixel-write and BRAM-port signal bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface fb_port_arbiter_if #(
  parameter int ADDR_BITS  = 15,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 8
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic                 disp_req;
  logic [ADDR_BITS-1:0] disp_addr;
  logic [DATA_W-1:0]    disp_data;
  logic                 disp_valid;
  logic                 vblank;
  logic                 wr_valid;
  logic                 wr_ready;
  logic [ADDR_BITS-1:0] wr_addr;
  logic [DATA_W-1:0]    wr_data;
  logic                 ram_en;
  logic                 ram_we;
  logic [ADDR_BITS-1:0] ram_addr;
  logic [DATA_W-1:0]    ram_wdata;
  logic [DATA_W-1:0]    ram_rdata;
  logic [LVL_W-1:0]     fifo_level;

  modport master (
    output disp_req, disp_addr, vblank, wr_valid, wr_addr, wr_data, ram_rdata,
    input  disp_data, disp_valid, wr_ready, ram_en, ram_we, ram_addr,
           ram_wdata, fifo_level
  );

  modport slave (
    input  disp_req, disp_addr, vblank, wr_valid, wr_addr, wr_data, ram_rdata,
    output disp_data, disp_valid, wr_ready, ram_en, ram_we, ram_addr,
           ram_wdata, fifo_level
  );
endinterface
`default_nettype wire

// File: rtl/fb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fb_port_arbiter
// Desc     : Shares one framebuffer BRAM port; display reads win, writes are
//            queued in a FIFO and drained on idle (or vblank-only) slots.
// Revision : 1.0 - initial release
// ============================================================================
module fb_port_arbiter #(
  parameter int ADDR_BITS  = 15,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int BLANK_ONLY = 0
) (
  input wire               clk,
  input wire               rst_n,
  fb_port_arbiter_if.slave bus
);

  localparam int              PTR_W    = $clog2(FIFO_DEPTH);
  localparam int              LVL_W    = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

  logic [ADDR_BITS-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [DATA_W-1:0]    fifo_data_q [FIFO_DEPTH];

  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]     level_q, level_d;
  logic                 ram_en_q, ram_en_d;
  logic                 ram_we_q, ram_we_d;
  logic [ADDR_BITS-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]    ram_wdata_q, ram_wdata_d;
  logic                 disp_valid_q, disp_valid_d;

  logic                 wr_ready;
  logic                 drain_ok;
  logic                 push;
  logic                 pop;

  always_comb begin
    // Held low during reset so no push can race the asynchronous clear.
    wr_ready     = rst_n && (level_q != FULL_LVL);
    drain_ok     = (BLANK_ONLY == 0) || bus.vblank;
    push         = bus.wr_valid && wr_ready;
    pop          = !bus.disp_req && (level_q != '0) && drain_ok;

    ram_en_d     = 1'b0;
    ram_we_d     = 1'b0;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    disp_valid_d = ram_en_q && !ram_we_q;

    if (bus.disp_req) begin
      ram_en_d   = 1'b1;
      ram_addr_d = bus.disp_addr;
    end else if (pop) begin
      ram_en_d    = 1'b1;
      ram_we_d    = 1'b1;
      ram_addr_d  = fifo_addr_q[rd_ptr_q];
      ram_wdata_d = fifo_data_q[rd_ptr_q];
      rd_ptr_d    = rd_ptr_q + PTR_W'(1);
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end

    unique case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      disp_valid_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      ram_en_q     <= ram_en_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      disp_valid_q <= disp_valid_d;
    end
  end

  // Entry storage needs no reset: the level counter alone marks validity.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= bus.wr_addr;
      fifo_data_q[wr_ptr_q] <= bus.wr_data;
    end
  end

  assign bus.wr_ready   = wr_ready;
  assign bus.ram_en     = ram_en_q;
  assign bus.ram_we     = ram_we_q;
  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_wdata  = ram_wdata_q;
  assign bus.disp_valid = disp_valid_q;
  assign bus.disp_data  = bus.ram_rdata;
  assign bus.fifo_level = level_q;

endmodule
`default_nettype wire

// File: tb/tb_fb_port_arbiter.sv
`default_nettype none
// Bench for fb_port_arbiter: one instance with BLANK_ONLY=0 and one with
// BLANK_ONLY=1, both fed the same stimulus and checked against a queue model.
module tb_fb_port_arbiter;
  localparam int AW    = 15;
  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int LW    = 4;
  localparam int MEMN  = 1 << AW;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          disp_req, vblank, wr_valid;
  logic [AW-1:0] disp_addr, wr_addr;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rdata0, rdata1;
  logic [DW-1:0] bram0 [MEMN];
  logic [DW-1:0] bram1 [MEMN];

  fb_port_arbiter_if #(.ADDR_BITS(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) if0 (), if1 ();

  fb_port_arbiter #(.ADDR_BITS(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .BLANK_ONLY(0))
    u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  fb_port_arbiter #(.ADDR_BITS(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .BLANK_ONLY(1))
    u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  assign if0.disp_req = disp_req;  assign if1.disp_req = disp_req;
  assign if0.disp_addr = disp_addr; assign if1.disp_addr = disp_addr;
  assign if0.vblank = vblank;      assign if1.vblank = vblank;
  assign if0.wr_valid = wr_valid;  assign if1.wr_valid = wr_valid;
  assign if0.wr_addr = wr_addr;    assign if1.wr_addr = wr_addr;
  assign if0.wr_data = wr_data;    assign if1.wr_data = wr_data;
  assign if0.ram_rdata = rdata0;   assign if1.ram_rdata = rdata1;

  // Registered-output BRAMs, one per instance.
  always @(posedge clk) begin
    if (if0.ram_en) begin
      if (if0.ram_we) bram0[if0.ram_addr] = if0.ram_wdata;
      else            rdata0 <= bram0[if0.ram_addr];
    end
    if (if1.ram_en) begin
      if (if1.ram_we) bram1[if1.ram_addr] = if1.ram_wdata;
      else            rdata1 <= bram1[if1.ram_addr];
    end
  end

  function automatic logic [DW-1:0] pre(input int a);
    return 32'h5A00_0000 + 32'(a * 3);
  endfunction

  // Reference model: expected port state, write queue as a ring, shadow memory.
  logic [DW-1:0] sh [2][MEMN];
  logic          m_en [2], m_we [2], m_vld [2], m_rdp [2];
  logic [AW-1:0] m_addr [2];
  logic [DW-1:0] m_wdata [2], m_data [2], m_rdx [2];
  logic [AW-1:0] mq_a [2][DEPTH];
  logic [DW-1:0] mq_d [2][DEPTH];
  int            mq_head [2], mq_cnt [2];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d t=%0t actual=%h required=%h", name, d, $time, act, exp);
    end
  endtask

  task automatic model_reset(input int d);
    m_en[d] = 0; m_we[d] = 0; m_vld[d] = 0; m_rdp[d] = 0;
    m_addr[d] = '0; m_wdata[d] = '0; m_data[d] = '0; m_rdx[d] = '0;
    mq_head[d] = 0; mq_cnt[d] = 0;
  endtask

  task automatic model_step(input int d);
    bit ready;
    int h, t;
    if (!rst_n) begin
      model_reset(d);
      return;
    end
    ready    = mq_cnt[d] < DEPTH;
    m_vld[d] = m_rdp[d];
    m_data[d] = m_rdx[d];
    if (disp_req) begin
      m_en[d] = 1; m_we[d] = 0; m_addr[d] = disp_addr;
      m_rdp[d] = 1; m_rdx[d] = sh[d][disp_addr];
    end else if (mq_cnt[d] > 0 && (d == 0 || vblank)) begin
      h = mq_head[d];
      m_en[d] = 1; m_we[d] = 1;
      m_addr[d] = mq_a[d][h]; m_wdata[d] = mq_d[d][h];
      sh[d][m_addr[d]] = m_wdata[d];
      mq_head[d] = (h + 1) % DEPTH;
      mq_cnt[d]--;
      m_rdp[d] = 0;
    end else begin
      m_en[d] = 0; m_we[d] = 0; m_rdp[d] = 0;
    end
    if (wr_valid && ready) begin
      t = (mq_head[d] + mq_cnt[d]) % DEPTH;
      mq_a[d][t] = wr_addr; mq_d[d][t] = wr_data;
      mq_cnt[d]++;
    end
  endtask

  task automatic peek(input int d, output logic en, output logic we, output logic [AW-1:0] a,
                      output logic [DW-1:0] wd, output logic vld, output logic [DW-1:0] dd,
                      output logic rdy, output logic [LW-1:0] lvl);
    if (d == 0) begin
      en = if0.ram_en; we = if0.ram_we; a = if0.ram_addr; wd = if0.ram_wdata;
      vld = if0.disp_valid; dd = if0.disp_data; rdy = if0.wr_ready; lvl = if0.fifo_level;
    end else begin
      en = if1.ram_en; we = if1.ram_we; a = if1.ram_addr; wd = if1.ram_wdata;
      vld = if1.disp_valid; dd = if1.disp_data; rdy = if1.wr_ready; lvl = if1.fifo_level;
    end
  endtask

  task automatic compare(input int d);
    logic en, we, vld, rdy;
    logic [AW-1:0] a;
    logic [DW-1:0] wd, dd;
    logic [LW-1:0] lvl;
    peek(d, en, we, a, wd, vld, dd, rdy, lvl);
    chk("ram_en", d, 64'(en), 64'(m_en[d]));
    chk("ram_we", d, 64'(we), 64'(m_we[d]));
    chk("ram_addr", d, 64'(a), 64'(m_addr[d]));
    chk("ram_wdata", d, 64'(wd), 64'(m_wdata[d]));
    chk("disp_valid", d, 64'(vld), 64'(m_vld[d]));
    if (m_vld[d]) chk("disp_data", d, 64'(dd), 64'(m_data[d]));
    chk("wr_ready", d, 64'(rdy), 64'(rst_n && mq_cnt[d] < DEPTH));
    chk("fifo_level", d, 64'(lvl), 64'(mq_cnt[d]));
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      model_step(d);
      compare(d);
    end
  endtask

  task automatic drive(input logic dr, input int da, input logic vb, input logic wv,
                       input int wa, input logic [DW-1:0] wd);
    disp_req = dr; disp_addr = AW'(da); vblank = vb;
    wr_valid = wv; wr_addr = AW'(wa); wr_data = wd;
  endtask

  typedef struct {
    logic          dr;
    int            da;
    logic          wv;
    int            wa;
    logic [DW-1:0] wd;
    logic          en, we;
    int            addr;
    logic          vld;
    logic [DW-1:0] data;
    int            lvl;
  } vec_t;

  vec_t tbl [7];

  initial begin : main
    logic en, we, vld, rdy, acc;
    logic [AW-1:0] a;
    logic [DW-1:0] wd, dd;
    logic [LW-1:0] lvl;
    int k;
    logic vb;

    tbl[0] = '{1'b0, 0, 1'b1, 'h10, 32'hDEADBEEF, 1'b0, 1'b0, 0,    1'b0, 32'h0,    1};
    tbl[1] = '{1'b0, 0, 1'b0, 0,    32'h0,        1'b1, 1'b1, 'h10, 1'b0, 32'h0,    0};
    tbl[2] = '{1'b1, 5, 1'b0, 0,    32'h0,        1'b1, 1'b0, 5,    1'b0, 32'h0,    0};
    tbl[3] = '{1'b1, 6, 1'b1, 'h20, 32'h1,        1'b1, 1'b0, 6,    1'b1, pre(5),   1};
    tbl[4] = '{1'b0, 0, 1'b1, 'h21, 32'h2,        1'b1, 1'b1, 'h20, 1'b1, pre(6),   1};
    tbl[5] = '{1'b0, 0, 1'b0, 0,    32'h0,        1'b1, 1'b1, 'h21, 1'b0, 32'h0,    0};
    tbl[6] = '{1'b0, 0, 1'b0, 0,    32'h0,        1'b0, 1'b0, 'h21, 1'b0, 32'h0,    0};

    for (int i = 0; i < MEMN; i++) begin
      bram0[i] = pre(i); bram1[i] = pre(i);
      sh[0][i] = pre(i); sh[1][i] = pre(i);
    end
    rdata0 = '0; rdata1 = '0;
    model_reset(0); model_reset(1);

    // Reset with a write request held.
    drive(0, 0, 1, 1, 'h10, 32'hDEADBEEF);
    #2 rst_n = 1'b0;
    repeat (3) cycle();
    for (int d = 0; d < 2; d++) begin
      peek(d, en, we, a, wd, vld, dd, rdy, lvl);
      chk("rst_wr_ready", d, 64'(rdy), 64'(0));
      chk("rst_ram_en", d, 64'(en), 64'(0));
      chk("rst_level", d, 64'(lvl), 64'(0));
    end
    rst_n = 1'b1;

    for (int r = 0; r < 7; r++) begin
      drive(tbl[r].dr, tbl[r].da, 1'b1, tbl[r].wv, tbl[r].wa, tbl[r].wd);
      cycle();
      for (int d = 0; d < 2; d++) begin
        peek(d, en, we, a, wd, vld, dd, rdy, lvl);
        chk("tbl_en", d, 64'(en), 64'(tbl[r].en));
        chk("tbl_we", d, 64'(we), 64'(tbl[r].we));
        chk("tbl_addr", d, 64'(a), 64'(tbl[r].addr));
        chk("tbl_valid", d, 64'(vld), 64'(tbl[r].vld));
        if (tbl[r].vld) chk("tbl_data", d, 64'(dd), 64'(tbl[r].data));
        chk("tbl_level", d, 64'(lvl), 64'(tbl[r].lvl));
      end
    end

    // Continuous reads while 9 writes are offered: FIFO fills, nothing drains.
    k = 0;
    for (int i = 0; i < 12; i++) begin
      drive(1, i, 1, k < 9, 'h200 + k, 32'h100 + k);
      acc = if0.wr_ready && (k < 9);
      cycle();
      if (acc) k++;
    end
    for (int d = 0; d < 2; d++) begin
      peek(d, en, we, a, wd, vld, dd, rdy, lvl);
      chk("full_level", d, 64'(lvl), 64'(8));
      chk("full_ready", d, 64'(rdy), 64'(0));
    end
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 1, k < 9, 'h200 + k, 32'h100 + k);
      acc = if0.wr_ready && (k < 9);
      cycle();
      if (acc) k++;
    end
    for (int d = 0; d < 2; d++) begin
      peek(d, en, we, a, wd, vld, dd, rdy, lvl);
      chk("drain_level", d, 64'(lvl), 64'(0));
    end

    // Alternating read/write slots with 3 queued writes.
    for (int i = 0; i < 3; i++) begin
      drive(1, 'h40 + i, 1, 1, 'h400 + i, 32'hA0 + i);
      cycle();
    end
    for (int i = 0; i < 6; i++) begin
      drive((i % 2) == 0, 'h50 + i, 1, 0, 0, 0);
      cycle();
    end
    for (int d = 0; d < 2; d++) begin
      peek(d, en, we, a, wd, vld, dd, rdy, lvl);
      chk("alt_level", d, 64'(lvl), 64'(0));
    end

    // Full FIFO: a pop edge does not admit a push; the following edge does.
    for (int i = 0; i < 8; i++) begin
      drive(1, i, 1, 1, 'h410 + i, 32'hB0 + i);
      cycle();
    end
    drive(0, 0, 1, 1, 'h418, 32'hB8);
    cycle();
    for (int d = 0; d < 2; d++) begin
      peek(d, en, we, a, wd, vld, dd, rdy, lvl);
      chk("pop_full_level", d, 64'(lvl), 64'(7));
    end
    drive(1, 0, 1, 1, 'h418, 32'hB8);
    cycle();
    for (int d = 0; d < 2; d++) begin
      peek(d, en, we, a, wd, vld, dd, rdy, lvl);
      chk("refill_level", d, 64'(lvl), 64'(8));
    end
    drive(0, 0, 1, 0, 0, 0);
    repeat (10) cycle();

    // Blank-only instance holds writes until vblank.
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1, 'h420 + i, 32'hC0 + i);
      cycle();
    end
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      cycle();
      chk("blank_hold_we", 1, 64'(if1.ram_we), 64'(0));
    end
    drive(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("blank_drain_we", 1, 64'(if1.ram_we), 64'(1));
    end
    chk("blank_level", 1, 64'(if1.fifo_level), 64'(0));

    // Reset mid-operation with 5 entries queued and a read in flight.
    for (int i = 0; i < 5; i++) begin
      drive(1, i, 1, 1, 'h300 + i, 32'hE0 + i);
      cycle();
    end
    drive(1, 7, 1, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      peek(d, en, we, a, wd, vld, dd, rdy, lvl);
      chk("midrst_level", d, 64'(lvl), 64'(0));
      chk("midrst_we", d, 64'(we), 64'(0));
      chk("midrst_valid", d, 64'(vld), 64'(0));
    end
    model_reset(0); model_reset(1);
    repeat (2) cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(i < 5, 'h300 + i, 1, 0, 0, 0);
      cycle();
      if (i >= 1) begin
        chk("stale_valid", 0, 64'(if0.disp_valid), 64'(1));
        chk("stale_data", 0, 64'(if0.disp_data), 64'(pre('h300 + i - 1)));
      end
    end

    // Randomized traffic with hazards on a small address window.
    vb = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) vb = ~vb;
      drive($urandom_range(0, 99) < 45, int'($urandom_range(0, 63)), vb,
            $urandom_range(0, 99) < 60, int'($urandom_range(0, 63)), $urandom);
      cycle();
    end
    drive(0, 0, 1, 0, 0, 0);
    repeat (12) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/fb_port_arbiter.md
Name: fb_port_arbiter

Overview:
- Shares the single framebuffer BRAM port between the display read path (pixel scan-out) and a pixel-write requester (drawing engine, UART loader).
- The display read always wins and is never stalled.
- Writes are buffered in an internal FIFO and drained on cycles when the display does not need the port.
- Optional tear-free mode holds writes until vertical blanking.
- Sits between the address generator, the framebuffer bram and any write source, all on the pixel clock domain.

Parameters:
- ADDR_BITS, 15, framebuffer word address width.
- DATA_W, 32, framebuffer word width.
- FIFO_DEPTH, 8, write FIFO entries; power of 2, minimum 2.
- BLANK_ONLY, 0, 1 = writes drain only while vblank is high; 0 = drain on any idle slot.

Ports:
- clk  in  1  pixel clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- disp_req  in  1  display needs a framebuffer word this cycle.
- disp_addr  in  ADDR_BITS  display read address.
- disp_data  out  DATA_W  read word; combinational copy of ram_rdata.
- disp_valid  out  1  disp_data valid this cycle.
- vblank  in  1  high during vertical blanking.
- wr_valid  in  1  write request.
- wr_ready  out  1  FIFO can accept a write.
- wr_addr  in  ADDR_BITS  write address.
- wr_data  in  DATA_W  write word.
- ram_en  out  1  BRAM enable.
- ram_we  out  1  BRAM write enable.
- ram_addr  out  ADDR_BITS  BRAM address.
- ram_wdata  out  DATA_W  BRAM write data.
- ram_rdata  in  DATA_W  BRAM read data, 1-cycle registered output.
- fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:

Reset (asynchronous, active-low):
- Clears the FIFO (level 0) and the pointers.
- Drives ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0, disp_valid=0.
- wr_ready follows empty FIFO, so it reads 1 once reset is deasserted; it is 0 while reset is low.

Port schedule (ram_* outputs are registered), evaluated at each rising edge k:
- READ: if disp_req=1, then after edge k: ram_en=1, ram_we=0, ram_addr=disp_addr. This happens regardless of FIFO state.
- WRITE: else if FIFO is non-empty and (BLANK_ONLY=0 or vblank=1):
  - pop the head entry;
  - after edge k: ram_en=1, ram_we=1, ram_addr/ram_wdata = head entry.
- IDLE: otherwise ram_en=0, ram_we=0; ram_addr and ram_wdata hold their previous values.

Read pipeline:
- A READ issued at edge k is captured by the BRAM at edge k+1.
- disp_valid=1 for exactly one cycle, after edge k+1 until edge k+2.
- disp_data = ram_rdata (combinational).
- Back-to-back reads give disp_valid high continuously.
- A WRITE slot never produces disp_valid.

Write FIFO:
- wr_ready = (fifo_level != FIFO_DEPTH), combinational from registered level.
- Push occurs on an edge where wr_valid && wr_ready.
- Full: wr_ready=0. A simultaneous pop does not enable a same-cycle push (no bypass).
- Simultaneous push and pop when not full: level unchanged; the entry is stored correctly.
- Empty: a pushed entry is eligible for issue no earlier than the next edge (minimum 1-cycle FIFO latency). The write appears on ram_* at the earliest after edge k+1 relative to the push at edge k.
- Writes issue strictly in push order.
- Pointers wrap modulo FIFO_DEPTH.
- fifo_level is registered and updated at the same edge as push/pop.

Hazards:
- A read of an address with a write still pending in the FIFO returns the old BRAM contents.
- No forwarding is performed; this is intended.

vblank:
- Sampled each edge with no synchronisation; it is on the same clock domain.
- With BLANK_ONLY=1 and vblank=0, the FIFO may fill; backpressure is signalled only via wr_ready.

Reset mid-operation:
- Any pending FIFO entries are discarded (not written).
- An in-flight disp_valid is cleared.
- ram_we drops immediately (asynchronous).

Test Plan:
- Reset with wr_valid=1 held: during reset wr_ready=0, ram_en=0, fifo_level=0. After release, the first push at edge 1 (addr 0x0010, data 0xDEADBEEF) issues as ram_we=1, ram_addr=0x0010 after edge 2, provided disp_req=0.
- disp_req=1 continuously with addresses 0,1,2,…; push 9 writes: wr_ready drops after 8 pushes, fifo_level=8, and no ram_we is asserted. disp_valid goes high after edge 2 and stays high, with disp_data equal to the preloaded words for addresses 0,1,2 in order. Drop disp_req: 8 writes drain in push order on 8 consecutive cycles, and the 9th is accepted after the first pop.
- Alternate disp_req 1/0 each cycle with 3 queued writes: reads and writes interleave 1:1, disp_valid is high only on read-derived cycles, and all 3 writes complete within 6 cycles.
- BLANK_ONLY=1: queue 4 writes with vblank=0 and disp_req=0 → no ram_we for 20 cycles. Raise vblank → 4 writes on 4 consecutive cycles, then fifo_level=0.
- Full FIFO, simultaneous pop with wr_valid=1 → no push that edge; level goes 8→7, and the next edge pushes (level 7→8).
- Assert reset with 5 entries queued → fifo_level=0 and ram_we=0 immediately. After release, a read of each queued address returns the old data (no stale writes).
